// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         read_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE   = CW'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CW-1:0]    w_count_nxt;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    assign w_wr_acc = wr_en && !r_full;
    assign w_rd_acc = rd_en && !r_empty;

    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == C_FULL);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= C_AF);
            r_almost_empty <= (w_count_nxt <= C_AE);
            r_overflow     <= wr_en && r_full;
            r_underflow    <= rd_en && r_empty;
        end
    end

    // NOTE: storage has no reset; only pointers and count define which words are valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= write_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty for a tidy idle bus.
            assign read_data = r_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] r_read_data;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)      r_read_data <= '0;
                else if (w_rd_acc) r_read_data <= r_mem[r_rd_ptr];
            end
            assign read_data = r_read_data;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
